// File: rtl/rf_pkg.sv
// Shared register-file definitions for the writeback arbiter.
// Widths, the hard-wired zero register and a width helper.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 5'd0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: picks the first valid requester
// at or after rr_ptr (modulo NUM_REQ), returns one-hot grant and its index.
import rf_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port with a registered output stage
// and RAW hazard flags. Optional macro RF_ARB_ZERO_GUARD_EN suppresses writes/hazards on r0.
import rf_pkg::*;

module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         A3,
    output logic [DATA_W-1:0]         WD3,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    output logic                      hazard1,
    output logic                      hazard2
);

    localparam int PTR_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] grant_raw;
    logic [PTR_W-1:0]   grant_idx;
    logic               accept;
    logic               wr_en;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               hit1;
    logic               hit2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant_raw),
        .grant_idx (grant_idx)
    );

    // No grant while reset is held, so nothing is accepted into a stage being cleared.
    assign req_ready = rst_n ? grant_raw : '0;
    assign accept    = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_nxt = rr_ptr;
        if (accept) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) ptr_nxt = '0;
            else                                  ptr_nxt = grant_idx + PTR_W'(1);
        end
    end

`ifdef RF_ARB_ZERO_GUARD_EN
    // Writes to r0 are consumed (ready given, pointer advances) but never reach the file.
    assign wr_en = accept && (sel_addr != ADDR_W'(RF_ZERO_ADDR));
`else
    assign wr_en = accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            RegWrite <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
        end else begin
            rr_ptr   <= ptr_nxt;
            RegWrite <= wr_en;
            if (wr_en) begin
                A3  <= sel_addr;
                WD3 <= sel_data;
            end
        end
    end

    always_comb begin
        hit1 = RegWrite && (A3 == rd_addr1);
        hit2 = RegWrite && (A3 == rd_addr2);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_addr1)) hit1 = 1'b1;
            if (req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == rd_addr2)) hit2 = 1'b1;
        end
    end

`ifdef RF_ARB_ZERO_GUARD_EN
    assign hazard1 = hit1 && (rd_addr1 != ADDR_W'(RF_ZERO_ADDR));
    assign hazard2 = hit2 && (rd_addr2 != ADDR_W'(RF_ZERO_ADDR));
`else
    assign hazard1 = hit1;
    assign hazard2 = hit2;
`endif

endmodule
